// File: rtl/img_streamer.sv
// Frame-buffer raster streamer: after a programmable idle gap, reads W*H pixels from base and forwards them as a contiguous valid burst.
// Optional IMG_STREAMER_COORD_EN adds pix_col/pix_row outputs aligned with img_dout_valid.
module img_streamer #(
  parameter int Img_Width  = 120,
  parameter int Img_Height = 100,
  parameter int Gap_Cycles = 1000,
  parameter int ADDR_W     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        img_dout,
  output logic              img_dout_valid,
  output logic              busy,
  output logic              frame_done
`ifdef IMG_STREAMER_COORD_EN
  ,
  output logic [9:0]        pix_col,
  output logic [9:0]        pix_row
`endif
);

  typedef enum logic [2:0] {IDLE, GAP, STREAM, FLUSH, DONE} state_t;

  localparam logic [9:0]  COL_LAST = 10'(Img_Width - 1);
  localparam logic [9:0]  ROW_LAST = 10'(Img_Height - 1);
  localparam logic [15:0] GAP_LAST = 16'(Gap_Cycles - 1);

  state_t            state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       gap_q, gap_d;
  logic [9:0]        col_q, col_d;
  logic [9:0]        row_q, row_d;
  logic              valid_q, valid_d;
  logic [7:0]        hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [9:0]        pcol_q, pcol_d;
  logic [9:0]        prow_q, prow_d;

  always_comb begin
    state_d = state_q;
    rd_en_d = rd_en_q;
    addr_d  = addr_q;
    gap_d   = gap_q;
    col_d   = col_q;
    row_d   = row_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = rd_en_q;
    hold_d  = valid_q ? mem_rdata : hold_q;
    pcol_d  = rd_en_q ? col_q : '0;
    prow_d  = rd_en_q ? row_q : '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          addr_d = frame_base;
          gap_d  = '0;
          col_d  = '0;
          row_d  = '0;
          if (Gap_Cycles == 0) begin
            state_d = STREAM;
            rd_en_d = 1'b1;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 16'd1;
        if (gap_q == GAP_LAST) begin
          state_d = STREAM;
          rd_en_d = 1'b1;
        end
      end
      STREAM: begin
        addr_d = addr_q + 1'b1;
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = (row_q == ROW_LAST) ? '0 : row_q + 10'd1;
          if (row_q == ROW_LAST) begin
            state_d = FLUSH;
            rd_en_d = 1'b0;
          end
        end else begin
          col_d = col_q + 10'd1;
        end
      end
      FLUSH: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      gap_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pcol_q  <= '0;
      prow_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pcol_q  <= pcol_d;
      prow_q  <= prow_d;
    end
  end

  // mem_rdata is already the memory's registered output, so it passes through
  // while valid; hold_q keeps the last pixel visible between bursts.
  always_comb img_dout = valid_q ? mem_rdata : hold_q;

  assign mem_rd_en      = rd_en_q;
  assign mem_addr       = addr_q;
  assign img_dout_valid = valid_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
`ifdef IMG_STREAMER_COORD_EN
  assign pix_col        = pcol_q;
  assign pix_row        = prow_q;
`endif

endmodule

// File: tb/tb_img_streamer.sv
// Randomized bench for img_streamer: two instances (4x3 gap 5, and 1x1 gap 0) checked against a per-cycle frame timeline model.
`timescale 1ns/1ps
module tb_img_streamer;
  localparam int AW = 20;
  localparam int WA = 4, HA = 3, GA = 5;
  localparam int WB = 1, HB = 1, GB = 0;

  logic clk = 1'b0, rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [AW-1:0] base_a = '0, base_b = '0;
  logic rd_a, rd_b, val_a, val_b, busy_a, busy_b, done_a, done_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [7:0] rdata_a = '0, rdata_b = '0, dout_a, dout_b;
  logic [9:0] col_a, row_a, col_b, row_b;
  logic [7:0] seed = 8'h5a;
  logic [7:0] last_pix [2];
  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

`ifndef IMG_STREAMER_COORD_EN
  assign col_a = '0; assign row_a = '0; assign col_b = '0; assign row_b = '0;
`endif

  img_streamer #(.Img_Width(WA), .Img_Height(HA), .Gap_Cycles(GA), .ADDR_W(AW)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .frame_base(base_a),
    .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .img_dout(dout_a), .img_dout_valid(val_a), .busy(busy_a), .frame_done(done_a)
`ifdef IMG_STREAMER_COORD_EN
    , .pix_col(col_a), .pix_row(row_a)
`endif
  );

  img_streamer #(.Img_Width(WB), .Img_Height(HB), .Gap_Cycles(GB), .ADDR_W(AW)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .frame_base(base_b),
    .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .img_dout(dout_b), .img_dout_valid(val_b), .busy(busy_b), .frame_done(done_b)
`ifdef IMG_STREAMER_COORD_EN
    , .pix_col(col_b), .pix_row(row_b)
`endif
  );

  function automatic logic [7:0] memv(input logic [AW-1:0] a);
    logic [AW-1:0] m;
    m = a * 20'd29;
    return m[7:0] ^ a[15:8] ^ seed;
  endfunction

  // Synchronous-read frame buffer: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_a) rdata_a <= memv(addr_a);
    if (rd_b) rdata_b <= memv(addr_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outs(input int sel, input logic rd_e, input logic [AW-1:0] addr_e,
                            input logic val_e, input logic [7:0] dout_e, input logic busy_e,
                            input logic done_e, input logic [9:0] col_e, input logic [9:0] row_e);
    if (sel == 0) begin
      check("a_rd_en", 32'(rd_a), 32'(rd_e));
      if (rd_e) check("a_addr", 32'(addr_a), 32'(addr_e));
      check("a_valid", 32'(val_a), 32'(val_e));
      check("a_dout", 32'(dout_a), 32'(dout_e));
      check("a_busy", 32'(busy_a), 32'(busy_e));
      check("a_done", 32'(done_a), 32'(done_e));
`ifdef IMG_STREAMER_COORD_EN
      check("a_col", 32'(col_a), 32'(col_e));
      check("a_row", 32'(row_a), 32'(row_e));
`endif
    end else begin
      check("b_rd_en", 32'(rd_b), 32'(rd_e));
      if (rd_e) check("b_addr", 32'(addr_b), 32'(addr_e));
      check("b_valid", 32'(val_b), 32'(val_e));
      check("b_dout", 32'(dout_b), 32'(dout_e));
      check("b_busy", 32'(busy_b), 32'(busy_e));
      check("b_done", 32'(done_b), 32'(done_e));
`ifdef IMG_STREAMER_COORD_EN
      check("b_col", 32'(col_b), 32'(col_e));
      check("b_row", 32'(row_b), 32'(row_e));
`endif
    end
  endtask

  task automatic check_reset_zero();
    check_outs(0, 1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b0, 10'd0, 10'd0);
    check("a_addr_rst", 32'(addr_a), 32'd0);
    check_outs(1, 1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b0, 10'd0, 10'd0);
    check("b_addr_rst", 32'(addr_b), 32'd0);
  endtask

  task automatic drive(input int sel, input logic s, input logic [AW-1:0] b);
    if (sel == 0) begin start_a = s; base_a = b; end
    else begin start_b = s; base_b = b; end
  endtask

  // Timeline model: start seen in cycle 0, gap occupies cycles 1..G, reads
  // issue in G+1..G+N, pixels valid in G+2..G+N+1, done in G+N+2.
  task automatic run_frame(input int sel, input logic [AW-1:0] b, input bit noisy,
                           input bit forced, input int abort_px);
    int g, w, h, np, n;
    logic val_e, rd_e;
    logic [7:0] dout_e;
    logic [9:0] col_e, row_e;
    g = (sel == 0) ? GA : GB;
    w = (sel == 0) ? WA : WB;
    h = (sel == 0) ? HA : HB;
    np = w * h;
    @(posedge clk); #1;
    drive(sel, 1'b1, b);
    for (int t = 0; t <= g + np + 3; t++) begin
      @(negedge clk);
      n = t - g - 2;
      val_e = (n >= 0) && (n < np);
      rd_e = (t >= g + 1) && (t <= g + np);
      if (val_e) dout_e = memv(b + AW'(n));
      else if (n >= np) dout_e = memv(b + AW'(np - 1));
      else dout_e = last_pix[sel];
      col_e = val_e ? 10'(n % w) : 10'd0;
      row_e = val_e ? 10'(n / w) : 10'd0;
      check_outs(sel, rd_e, b + AW'(t - g - 1), val_e, dout_e,
                 (t >= 1) && (t <= g + np + 2), t == g + np + 2, col_e, row_e);
      if (abort_px >= 0 && n == abort_px - 1) begin
        #2 rst = 1'b1;
        #1 check_reset_zero();
        drive(sel, 1'b0, '0);
        last_pix[0] = 8'h00;
        last_pix[1] = 8'h00;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check_reset_zero();
        end
        return;
      end
      @(posedge clk); #1;
      drive(sel, 1'b0, AW'($urandom));
      if (noisy && (t + 1 <= g + np + 2) && $urandom_range(0, 2) == 0)
        drive(sel, 1'b1, AW'($urandom));
      if (forced && (t + 1 == g + 3 || t + 1 == g + np + 2))
        drive(sel, 1'b1, AW'($urandom));
    end
    last_pix[sel] = memv(b + AW'(np - 1));
    drive(sel, 1'b0, '0);
  endtask

  initial begin
    last_pix[0] = 8'h00;
    last_pix[1] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_zero();
    @(posedge clk); #1 rst = 1'b0;

    run_frame(0, 20'h00100, 1'b0, 1'b1, -1);
    run_frame(0, 20'hFFFFC, 1'b0, 1'b0, -1);
    run_frame(1, 20'h12345, 1'b0, 1'b1, -1);
    run_frame(0, 20'h00200, 1'b0, 1'b0, 5);
    run_frame(0, 20'h00200, 1'b0, 1'b0, -1);

    for (int i = 0; i < 14; i++) begin
      seed = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_frame(int'($urandom_range(0, 1)), AW'($urandom), 1'b1, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
